// File: rtl/xsleena_mcu_pkg.sv
// Shared types and reset constants for the main-CPU <-> MCU mailbox.
// Optional build macro: XSLEENA_NO_MCU_EN (bootleg board without MCU).
package xsleena_mcu_pkg;

    typedef enum logic [1:0] {RUN, RST_HOLD, RST_REL} mcu_rst_state_t;

    localparam int MCU_LATCH_W = 8;

    localparam logic [MCU_LATCH_W-1:0] LATCH_RST = '0;
    localparam logic                   FULL_RST  = 1'b0;

endpackage

// File: rtl/xsleena_mcu_link_strobe.sv
// Falling-edge detector for an active-low multi-cycle strobe.
// The prev flop resets high so a strobe already low at reset release fires once.
module strobe_fall_det (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic strobe_i,
    output logic fall_o
);

    logic prev_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) prev_q <= 1'b1;
        else         prev_q <= strobe_i;
    end

    assign fall_o = prev_q & ~strobe_i;

endmodule

// File: rtl/xsleena_mcu_link.sv
// Main-CPU <-> 68705 mailbox: two byte latches, status flags and MCU reset sequencer.
// Define XSLEENA_NO_MCU_EN for the no-MCU build (latches only, status tied off).
module xsleena_mcu_link
    import xsleena_mcu_pkg::*;
#(
    parameter int RESET_CYCLES = 64,
    parameter int RST_CNT_W    = 8
) (
    input  logic                   clk,
    input  logic                   RSTn,
    input  logic                   W3A0En,
    input  logic                   R3A04n,
    input  logic                   R3A06n,
    input  logic [MCU_LATCH_W-1:0] DB_in,
    output logic [MCU_LATCH_W-1:0] DB_out,
    input  logic                   mcu_rd_n,
    input  logic                   mcu_wr_n,
    input  logic [MCU_LATCH_W-1:0] mcu_din,
    output logic [MCU_LATCH_W-1:0] mcu_dout,
    output logic                   mcu_int_n,
    output logic                   mcu_rst_n,
    output logic                   P5READn,
    output logic                   P5ACCEPTn
);

    logic wr_fall, rd_fall, mrd_fall, mwr_fall;
    logic mcu_en, seq_clr;

    logic [MCU_LATCH_W-1:0] m2c_byte_q, m2c_byte_d;
    logic [MCU_LATCH_W-1:0] c2m_byte_q, c2m_byte_d;
    logic                   m2c_full_q, m2c_full_d;
    logic                   c2m_full_q, c2m_full_d;

    strobe_fall_det u_wr (.clk_i(clk), .rst_ni(RSTn), .strobe_i(W3A0En),   .fall_o(wr_fall));
    strobe_fall_det u_rd (.clk_i(clk), .rst_ni(RSTn), .strobe_i(R3A04n),   .fall_o(rd_fall));
    strobe_fall_det u_mr (.clk_i(clk), .rst_ni(RSTn), .strobe_i(mcu_rd_n), .fall_o(mrd_fall));
    strobe_fall_det u_mw (.clk_i(clk), .rst_ni(RSTn), .strobe_i(mcu_wr_n), .fall_o(mwr_fall));

    // Write edges are applied last so a simultaneous clear loses.
    always_comb begin
        m2c_byte_d = m2c_byte_q;
        c2m_byte_d = c2m_byte_q;
        m2c_full_d = m2c_full_q;
        c2m_full_d = c2m_full_q;
        if (seq_clr) begin
            m2c_full_d = 1'b0;
            c2m_full_d = 1'b0;
        end
        if (mcu_en && mrd_fall) m2c_full_d = 1'b0;
        if (rd_fall)            c2m_full_d = 1'b0;
        if (wr_fall) begin
            m2c_byte_d = DB_in;
            m2c_full_d = 1'b1;
        end
        if (mcu_en && mwr_fall) begin
            c2m_byte_d = mcu_din;
            c2m_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!RSTn) begin
            m2c_byte_q <= LATCH_RST;
            c2m_byte_q <= LATCH_RST;
            m2c_full_q <= FULL_RST;
            c2m_full_q <= FULL_RST;
        end else begin
            m2c_byte_q <= m2c_byte_d;
            c2m_byte_q <= c2m_byte_d;
            m2c_full_q <= m2c_full_d;
            c2m_full_q <= c2m_full_d;
        end
    end

    assign DB_out   = c2m_byte_q;
    assign mcu_dout = m2c_byte_q;

`ifdef XSLEENA_NO_MCU_EN

    assign mcu_en    = 1'b1;
    assign seq_clr   = 1'b0;
    assign P5READn   = 1'b0;
    assign P5ACCEPTn = 1'b0;
    assign mcu_rst_n = 1'b0;
    assign mcu_int_n = 1'b1;

`else

    localparam logic [RST_CNT_W-1:0] CNT_LAST = RST_CNT_W'(RESET_CYCLES - 1);

    logic           rq_fall;
    mcu_rst_state_t state_q, state_d;
    logic [RST_CNT_W-1:0] cnt_q, cnt_d;
    logic p5read_q, p5acc_q, int_q, mrst_q;

    strobe_fall_det u_rq (.clk_i(clk), .rst_ni(RSTn), .strobe_i(R3A06n), .fall_o(rq_fall));

    assign mcu_en  = (state_q == RUN);
    assign seq_clr = rq_fall;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            RUN: begin
                if (rq_fall) begin
                    state_d = RST_HOLD;
                    cnt_d   = '0;
                end
            end
            RST_HOLD: begin
                if (rq_fall)               cnt_d   = '0;
                else if (cnt_q == CNT_LAST) state_d = RST_REL;
                else                       cnt_d   = cnt_q + RST_CNT_W'(1);
            end
            RST_REL: begin
                if (rq_fall) begin
                    state_d = RST_HOLD;
                    cnt_d   = '0;
                end else begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Status flops track next-state so they line up with the flag flops.
    always_ff @(posedge clk) begin
        if (!RSTn) begin
            state_q  <= RST_HOLD;
            cnt_q    <= '0;
            p5read_q <= 1'b1;
            p5acc_q  <= 1'b0;
            int_q    <= 1'b1;
            mrst_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            p5read_q <= ~c2m_full_d;
            p5acc_q  <= m2c_full_d;
            int_q    <= ~m2c_full_d;
            mrst_q   <= (state_d != RST_HOLD);
        end
    end

    assign P5READn   = p5read_q;
    assign P5ACCEPTn = p5acc_q;
    assign mcu_int_n = int_q;
    assign mcu_rst_n = mrst_q;

`endif

endmodule

// File: tb/tb_xsleena_mcu_link.sv
// Directed self-checking bench for the xsleena_mcu_link mailbox (default build).
module tb_xsleena_mcu_link;

    logic       clk = 1'b0;
    logic       RSTn, W3A0En, R3A04n, R3A06n, mcu_rd_n, mcu_wr_n;
    logic [7:0] DB_in, DB_out, mcu_din, mcu_dout;
    logic       mcu_int_n, mcu_rst_n, P5READn, P5ACCEPTn;

    int nchk  = 0;
    int npass = 0;
    int nfail = 0;
    int n;

    always #5 clk = ~clk;

    xsleena_mcu_link dut (
        .clk(clk), .RSTn(RSTn),
        .W3A0En(W3A0En), .R3A04n(R3A04n), .R3A06n(R3A06n),
        .DB_in(DB_in), .DB_out(DB_out),
        .mcu_rd_n(mcu_rd_n), .mcu_wr_n(mcu_wr_n),
        .mcu_din(mcu_din), .mcu_dout(mcu_dout),
        .mcu_int_n(mcu_int_n), .mcu_rst_n(mcu_rst_n),
        .P5READn(P5READn), .P5ACCEPTn(P5ACCEPTn)
    );

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        nchk++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Count clocks until mcu_rst_n rises, bounded.
    task automatic wait_rel(output int cnt);
        cnt = 0;
        do begin
            step(1);
            cnt++;
        end while (!mcu_rst_n && cnt < 200);
    endtask

    initial begin
        RSTn = 0; W3A0En = 1; R3A04n = 1; R3A06n = 1;
        mcu_rd_n = 1; mcu_wr_n = 1; DB_in = 8'h00; mcu_din = 8'h00;

        step(3);
        chk("rst_db_out", DB_out, 8'h00);
        chk("rst_mcu_dout", mcu_dout, 8'h00);
        chk("rst_int", mcu_int_n, 1);
        chk("rst_p5read", P5READn, 1);
        chk("rst_p5acc", P5ACCEPTn, 0);
        chk("rst_mcu_rst", mcu_rst_n, 0);
        RSTn = 1;
        wait_rel(n);
        chk("rst_hold_len", n, 64);
        step(2);
        chk("run_mcu_rst", mcu_rst_n, 1);

        W3A0En = 0; DB_in = 8'hA5;
        step(1);
        chk("mw_dout", mcu_dout, 8'hA5);
        chk("mw_int", mcu_int_n, 0);
        chk("mw_acc", P5ACCEPTn, 1);
        step(3);
        W3A0En = 1; DB_in = 8'hFF;
        step(1);
        chk("mw_once", mcu_dout, 8'hA5);
        mcu_rd_n = 0;
        step(1);
        chk("mr_acc", P5ACCEPTn, 0);
        chk("mr_int", mcu_int_n, 1);
        mcu_rd_n = 1;
        step(1);

        mcu_din = 8'h3C; mcu_wr_n = 0;
        step(1);
        chk("cw_read", P5READn, 0);
        chk("cw_db", DB_out, 8'h3C);
        mcu_wr_n = 1;
        step(1);
        R3A04n = 0;
        step(1);
        chk("rd_clr", P5READn, 1);
        mcu_din = 8'h5A; mcu_wr_n = 0;
        step(1);
        chk("cw2_read", P5READn, 0);
        chk("cw2_db", DB_out, 8'h5A);
        mcu_wr_n = 1;
        step(2);
        chk("rd_once", P5READn, 0);
        R3A04n = 1;
        step(1);
        R3A04n = 0;
        step(1);
        chk("rd2_clr", P5READn, 1);
        R3A04n = 1;
        step(1);

        W3A0En = 0; DB_in = 8'h22;
        step(1);
        W3A0En = 1;
        step(1);
        chk("pre_same_acc", P5ACCEPTn, 1);
        W3A0En = 0; DB_in = 8'h11; mcu_rd_n = 0;
        step(1);
        chk("same_acc", P5ACCEPTn, 1);
        chk("same_dout", mcu_dout, 8'h11);
        chk("same_int", mcu_int_n, 0);
        W3A0En = 1; mcu_rd_n = 1;
        step(1);

        mcu_din = 8'h77; mcu_wr_n = 0;
        step(1);
        mcu_wr_n = 1;
        chk("pre_seq_read", P5READn, 0);
        R3A06n = 0;
        step(1);
        R3A06n = 1;
        chk("seq_rst", mcu_rst_n, 0);
        chk("seq_clr_read", P5READn, 1);
        chk("seq_clr_acc", P5ACCEPTn, 0);
        mcu_din = 8'h99; mcu_wr_n = 0;
        step(1);
        mcu_wr_n = 1;
        chk("hold_cw_read", P5READn, 1);
        chk("hold_cw_db", DB_out, 8'h77);
        W3A0En = 0; DB_in = 8'hC3;
        step(1);
        W3A0En = 1;
        chk("hold_mw_acc", P5ACCEPTn, 1);
        chk("hold_mw_dout", mcu_dout, 8'hC3);
        mcu_rd_n = 0;
        step(1);
        mcu_rd_n = 1;
        chk("hold_mr_acc", P5ACCEPTn, 1);
        step(16);
        chk("hold_mid_rst", mcu_rst_n, 0);
        R3A06n = 0;
        step(1);
        R3A06n = 1;
        wait_rel(n);
        chk("seq_total_len", n + 20, 84);
        step(2);
        chk("seq_run", mcu_rst_n, 1);

        R3A06n = 0;
        step(1);
        R3A06n = 1;
        W3A0En = 0; DB_in = 8'hE7;
        step(1);
        W3A0En = 1;
        chk("b_full_acc", P5ACCEPTn, 1);
        step(5);
        RSTn = 0;
        step(1);
        chk("b_acc", P5ACCEPTn, 0);
        chk("b_int", mcu_int_n, 1);
        chk("b_read", P5READn, 1);
        chk("b_dout", mcu_dout, 8'h00);
        chk("b_db", DB_out, 8'h00);
        chk("b_rst", mcu_rst_n, 0);
        RSTn = 1;
        wait_rel(n);
        chk("b_hold_len", n, 64);
        step(2);
        mcu_din = 8'h42; mcu_wr_n = 0;
        step(1);
        mcu_wr_n = 1;
        chk("post_cw_read", P5READn, 0);
        chk("post_cw_db", DB_out, 8'h42);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
